uart_tx_periph: RTL and testbench

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_tx_fifo.sv | 77 +++++++
 rtl/uart_tx_periph.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package uart_pkg;

    // Register offsets relative to BASE_ADDR.
    localparam logic [15:0] DATA_OFS   = 16'd0;
    localparam logic [15:0] STATUS_OFS = 16'd1;

    // STATUS register bit positions; bits 6:4 are reserved and read as 0.
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_IRQ_EN = 3;
    localparam int ST_BUSY   = 7;

    // Serial frame shape: 8 data bits, no parity, one stop bit.
    localparam int CHAR_BITS = 8;

    typedef enum logic [1:0] {
        SH_IDLE  = 2'd0,
        SH_START = 2'd1,
        SH_DATA  = 2'd2,
        SH_STOP  = 2'd3
    } sh_state_e;

    // Assemble the STATUS byte from its individual flags.
    function automatic logic [7:0] status_pack(
        input logic full,
        input logic empty,
        input logic ovf,
        input logic irq_en,
        input logic busy
    );
        logic [7:0] s;
        s            = 8'h00;
        s[ST_FULL]   = full;
        s[ST_EMPTY]  = empty;
        s[ST_OVF]    = ovf;
        s[ST_IRQ_EN] = irq_en;
        s[ST_BUSY]   = busy;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO, show-ahead read port (pop_dat valid whenever !empty).
// Latency: a pushed byte is visible on pop_dat the cycle after the push edge.
// Backpressure: pushes while full are ignored unless a pop happens on the same edge.
//
// Ports:
//   clk_m1, rst_n      clock and async active-low reset (reset empties the FIFO)
//   push, push_dat     write request and byte
//   pop                read request; ignored while empty
//   pop_dat            byte at the head of the FIFO
//   full, empty, count occupancy, registered
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_m1,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             push_acc;
    logic             pop_acc;

    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    always_comb begin
        pop_acc  = pop && (count_q != '0);
        push_acc = push && ((count_q != CNT_FULL) || pop_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
    end

    always_ff @(posedge clk_m1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_m1) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_periph.sv
// 6502-bus UART transmitter: DATA/STATUS registers, TX FIFO, 8N1 shifter.
// Latency: reads 1 cycle; a byte reaches tx 1 cycle after it is popped.
// Backpressure: none on the bus; DATA writes while full are dropped and set OVF.
//
// Ports:
//   clk_m1, rst_n   clock and async active-low reset
//   addr, RW        bus address and direction (1 = read)
//   data_i          CPU write data
//   data_o          registered read data (held on unmapped reads)
//   tx              serial line, idle high
//   irq             FIFO empty and shifter idle, gated by IRQ_EN
module uart_tx_periph #(
    parameter logic [15:0] BASE_ADDR  = 16'h0F00,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_m1,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_i,
    input  logic        RW,
    output logic [7:0]  data_o,
    output logic        tx,
    output logic        irq
);

    import uart_pkg::*;

    localparam logic [15:0] DATA_ADDR   = BASE_ADDR + DATA_OFS;
    localparam logic [15:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
    localparam int          FAW         = $clog2(FIFO_DEPTH);
    localparam logic [FAW:0] FIFO_CNT_FULL = (FAW+1)'(FIFO_DEPTH);
    localparam int          CW          = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT    = 3'(CHAR_BITS - 1);

    // Shifter state
    sh_state_e      state_q, state_d;
    logic [CW-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;

    // Register state
    logic           ovf_q, ovf_d;
    logic           irq_en_q, irq_en_d;
    logic [7:0]     data_o_q, data_o_d;

    // FIFO interface
    logic           fifo_push;
    logic           fifo_pop;
    logic [7:0]     fifo_rd_dat;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FAW:0]   fifo_count;

    // Decode and status helpers
    logic           wr_data, wr_status, rd_data, rd_status;
    logic           baud_done;
    logic           busy;
    logic [FAW:0]   cnt_nxt;
    logic [7:0]     status_nxt;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_m1   (clk_m1),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (data_i),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign baud_done = (baud_cnt_q == BAUD_LAST);

    //------------------------------------------------------------------
    // Shifter FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge clk_m1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // Shifter FSM: next state. The pop is a transition action: it happens
    // from IDLE, or at the end of STOP so frames run back-to-back.
    //------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            SH_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = SH_START;
                end
            end
            SH_START: begin
                if (baud_done) begin
                    state_d = SH_DATA;
                end
            end
            SH_DATA: begin
                if (baud_done && (bit_cnt_q == LAST_BIT)) begin
                    state_d = SH_STOP;
                end
            end
            SH_STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = SH_START;
                    end else begin
                        state_d = SH_IDLE;
                    end
                end
            end
            default: state_d = SH_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Shifter FSM: outputs
    //------------------------------------------------------------------
    always_comb begin
        tx   = 1'b1;
        busy = 1'b1;
        unique case (state_q)
            SH_IDLE:  busy = 1'b0;
            SH_START: tx   = 1'b0;
            SH_DATA:  tx   = shreg_q[0];
            SH_STOP:  tx   = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    //------------------------------------------------------------------
    // Baud counter, bit counter and shift register
    //------------------------------------------------------------------
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        if (fifo_pop) begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shreg_d    = fifo_rd_dat;
        end else if (state_q == SH_IDLE) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_done ? '0 : baud_cnt_q + CW'(1);
            if ((state_q == SH_DATA) && baud_done) begin
                shreg_d   = {1'b0, shreg_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    //------------------------------------------------------------------
    // Bus decode, register updates and read mux
    //------------------------------------------------------------------
    always_comb begin
        wr_data   = !RW && (addr == DATA_ADDR);
        wr_status = !RW && (addr == STATUS_ADDR);
        rd_data   =  RW && (addr == DATA_ADDR);
        rd_status =  RW && (addr == STATUS_ADDR);

        fifo_push = wr_data && (!fifo_full || fifo_pop);

        ovf_d = ovf_q;
        if (wr_status && data_i[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (wr_data && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end

        irq_en_d = wr_status ? data_i[ST_IRQ_EN] : irq_en_q;

        // STATUS is built from post-edge values so a read agrees with the
        // register state it is presented alongside.
        cnt_nxt    = fifo_count + {{FAW{1'b0}}, fifo_push} - {{FAW{1'b0}}, fifo_pop};
        status_nxt = status_pack((cnt_nxt == FIFO_CNT_FULL),
                                 (cnt_nxt == '0) && (state_d == SH_IDLE),
                                 ovf_d,
                                 irq_en_d,
                                 (state_d != SH_IDLE));

        data_o_d = data_o_q;
        if (rd_status) begin
            data_o_d = status_nxt;
        end else if (rd_data) begin
            data_o_d = 8'h00;
        end
    end

    always_ff @(posedge clk_m1 or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            data_o_q   <= 8'h00;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            data_o_q   <= data_o_d;
        end
    end

    assign data_o = data_o_q;
    assign irq    = irq_en_q && fifo_empty && (state_q == SH_IDLE);

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with CLK_DIV=4, FIFO_DEPTH=4.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: n/a.
module tb_uart_tx_periph;

    localparam logic [15:0] DATA_A   = 16'h0F00;
    localparam logic [15:0] STATUS_A = 16'h0F01;
    localparam logic [15:0] UNMAP_A  = 16'h0F02;
    localparam logic [15:0] IDLE_A   = 16'h0000;

    logic        clk_m1;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  data_i;
    logic        RW;
    logic [7:0]  data_o;
    logic        tx;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [6];

    uart_tx_periph #(
        .BASE_ADDR  (16'h0F00),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_m1 (clk_m1),
        .rst_n  (rst_n),
        .addr   (addr),
        .data_i (data_i),
        .RW     (RW),
        .data_o (data_o),
        .tx     (tx),
        .irq    (irq)
    );

    initial begin
        clk_m1 = 1'b0;
        forever #5 clk_m1 = ~clk_m1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_m1);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr   = a;
        data_i = d;
        RW     = 1'b0;
        tick();
        RW     = 1'b1;
        addr   = IDLE_A;
        data_i = 8'h00;
    endtask

    task automatic bus_read(input logic [15:0] a);
        addr = a;
        RW   = 1'b1;
        tick();
        addr = IDLE_A;
    endtask

    // Line level p cycles into a frame carrying byte b (4 cycles per bit).
    function automatic logic frame_bit(input logic [7:0] b, input int p);
        int j;
        if (p < 0 || p >= 40) return 1'b1;
        j = p / 4;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    initial begin
        logic e;
        int   p;

        rst_n  = 1'b0;
        addr   = IDLE_A;
        data_i = 8'h00;
        RW     = 1'b1;
        sb[0] = 8'h11; sb[1] = 8'h22; sb[2] = 8'h33;
        sb[3] = 8'h44; sb[4] = 8'h55; sb[5] = 8'h77;

        // Reset values
        #12;
        check("rst_tx", {7'd0, tx}, 8'h01);
        check("rst_data_o", data_o, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h00);
        @(posedge clk_m1);
        #1;
        rst_n = 1'b1;

        // Single frame of 0x41 with STATUS held on the bus to watch BUSY
        bus_write(DATA_A, 8'h41);
        check("pre_pop_tx", {7'd0, tx}, 8'h01);
        addr = STATUS_A;
        for (int k = 1; k <= 44; k++) begin
            tick();
            check($sformatf("f41_tx_%0d", k), {7'd0, tx}, {7'd0, frame_bit(8'h41, k - 1)});
            check($sformatf("f41_busy_%0d", k), {7'd0, data_o[7]}, (k <= 40) ? 8'h01 : 8'h00);
        end
        check("f41_idle_status", data_o, 8'h02);
        addr = IDLE_A;

        // Six back-to-back writes: one popped, four queued, sixth dropped.
        // Then OVF clear, and a push coinciding with a pop while full.
        bus_write(DATA_A, 8'h11);
        bus_write(DATA_A, 8'h22);
        bus_write(DATA_A, 8'h33);
        bus_write(DATA_A, 8'h44);
        bus_write(DATA_A, 8'h55);
        bus_write(DATA_A, 8'h66);
        for (int k = 5; k <= 245; k++) begin
            if (k == 6)  check("ovf_status", data_o, 8'h85);
            if (k == 11) check("ovf_cleared", data_o, 8'h81);
            if (k == 42) check("push_pop_full", data_o, 8'h81);
            p = k - 1;
            e = (p >= 240) ? 1'b1 : frame_bit(sb[p / 40], p % 40);
            check($sformatf("stream_tx_%0d", k), {7'd0, tx}, {7'd0, e});
            RW     = 1'b1;
            addr   = IDLE_A;
            data_i = 8'h00;
            if (k == 5 || k == 10 || k == 41 || k == 245) addr = STATUS_A;
            if (k == 9) begin
                RW = 1'b0; addr = STATUS_A; data_i = 8'h04;
            end
            if (k == 40) begin
                RW = 1'b0; addr = DATA_A; data_i = 8'h77;
            end
            tick();
        end
        check("stream_end_status", data_o, 8'h02);
        RW   = 1'b1;
        addr = IDLE_A;

        // IRQ enable and completion interrupt
        bus_write(STATUS_A, 8'h08);
        check("irq_idle_en", {7'd0, irq}, 8'h01);
        bus_write(DATA_A, 8'h3C);
        check("irq_queued", {7'd0, irq}, 8'h00);
        for (int j = 1; j <= 44; j++) begin
            tick();
            check($sformatf("irq_%0d", j), {7'd0, irq}, (j >= 41) ? 8'h01 : 8'h00);
        end
        bus_read(STATUS_A);
        check("irq_status", data_o, 8'h0A);

        // Reset in the middle of DATA bit 3, with a second byte queued
        bus_write(DATA_A, 8'h00);
        bus_write(DATA_A, 8'h5A);
        repeat (17) tick();
        check("bit3_tx", {7'd0, tx}, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx", {7'd0, tx}, 8'h01);
        check("abort_irq", {7'd0, irq}, 8'h00);
        check("abort_data_o", data_o, 8'h00);
        @(posedge clk_m1);
        #1;
        rst_n = 1'b1;
        bus_read(STATUS_A);
        check("post_rst_status", data_o, 8'h02);
        repeat (3) tick();
        check("post_rst_tx", {7'd0, tx}, 8'h01);

        // Write on the very first edge after reset release
        rst_n = 1'b0;
        @(posedge clk_m1);
        #1;
        rst_n = 1'b1;
        bus_write(DATA_A, 8'hA5);
        check("first_wr_prepop", {7'd0, tx}, 8'h01);
        tick();
        check("first_wr_start", {7'd0, tx}, 8'h00);
        bus_read(STATUS_A);
        check("first_wr_busy", data_o, 8'h80);
        repeat (40) tick();
        check("first_wr_done_tx", {7'd0, tx}, 8'h01);

        // Unmapped address and DATA read
        bus_read(STATUS_A);
        check("unmap_base", data_o, 8'h02);
        bus_write(UNMAP_A, 8'hFF);
        check("unmap_wr_data_o", data_o, 8'h02);
        bus_read(UNMAP_A);
        check("unmap_rd_hold", data_o, 8'h02);
        tick();
        check("unmap_no_frame", {7'd0, tx}, 8'h01);
        check("unmap_no_irq", {7'd0, irq}, 8'h00);
        bus_read(STATUS_A);
        check("unmap_status", data_o, 8'h02);
        bus_read(DATA_A);
        check("data_read_zero", data_o, 8'h00);
        bus_read(UNMAP_A);
        check("unmap_rd_hold2", data_o, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
